// File: rtl/exc_ctrl_if.sv
// Pipeline-side bundle for the trap sequencer: memory-stage exception inputs
// plus the fetch redirect, flush/stall and exception-register outputs.
interface exc_ctrl_if;
  logic [4:0]  vector_mem;
  logic        mem_valid;
  logic [31:0] pc_mem;
  logic [31:0] data_address;
  logic        eret;
  logic        irq;
  logic        kill_mem;
  logic        flush;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic [31:0] badvaddr;
  logic        s_u;
  logic        ie;

  // Pipeline side: drives the memory-stage state, consumes redirect/status.
  modport master (
    output vector_mem, mem_valid, pc_mem, data_address, eret, irq,
    input  kill_mem, flush, stall, pc_load, pc_target,
    input  epc, cause, badvaddr, s_u, ie
  );

  // Trap sequencer side.
  modport slave (
    input  vector_mem, mem_valid, pc_mem, data_address, eret, irq,
    output kill_mem, flush, stall, pc_load, pc_target,
    output epc, cause, badvaddr, s_u, ie
  );
endinterface

// File: rtl/exc_ctrl.sv
// Trap sequencer: takes exceptions/interrupts/eret from the memory stage,
// holds EPC/cause/badvaddr and mode/IE, and sequences flush then PC redirect.
module exc_ctrl #(
  parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [4:0]  INT_VECTOR   = 5'b00010
) (
  input logic      clk,
  input logic      rst,
  exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic [4:0] CAUSE_MIS = 5'b01011;
  localparam logic [4:0] CAUSE_PRT = 5'b01001;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_cnt;
  logic        r_ret;
  logic        r_s_u;
  logic        r_ie;
  logic        r_s_u_p;
  logic        r_ie_p;
  logic [31:0] r_epc;
  logic [4:0]  r_cause;
  logic [31:0] r_badvaddr;

  logic        w_active;
  logic        w_exc;
  logic        w_ret;
  logic        w_int;
  logic        w_take_trap;
  logic [4:0]  w_trap_cause;
  logic        w_save_bad;
  logic        w_kill_mem;
  logic        w_flush;
  logic        w_stall;
  logic        w_pc_load;
  logic [31:0] w_pc_target;

  // Event decode: exception beats eret, eret beats interrupt.
  assign w_active     = (r_state == RUN) && bus.mem_valid;
  assign w_exc        = w_active && (bus.vector_mem != 5'd0);
  assign w_ret        = w_active && (bus.vector_mem == 5'd0) && bus.eret;
  assign w_int        = w_active && (bus.vector_mem == 5'd0) && !bus.eret
                        && bus.irq && r_ie;
  assign w_take_trap  = w_exc || w_int;
  assign w_trap_cause = w_exc ? bus.vector_mem : INT_VECTOR;
  assign w_save_bad   = w_exc && ((bus.vector_mem == CAUSE_MIS) ||
                                  (bus.vector_mem == CAUSE_PRT));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (w_take_trap || w_ret) w_next_state = FLUSH;
      FLUSH:   if (r_cnt == 3'd0)        w_next_state = LOAD;
      LOAD:    w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  // Output decode; pc_target is only meaningful in LOAD.
  always_comb begin
    w_kill_mem  = w_exc || w_int;
    w_flush     = 1'b0;
    w_stall     = (r_state != RUN);
    w_pc_load   = 1'b0;
    w_pc_target = '0;
    case (r_state)
      FLUSH: w_flush = 1'b1;
      LOAD: begin
        w_pc_load   = 1'b1;
        w_pc_target = r_ret ? r_epc : (VEC_BASE + {23'd0, r_cause, 4'b0000});
      end
      default: ;
    endcase
  end

  // Exception registers, flush counter and mode/IE status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_ret      <= 1'b0;
      r_s_u      <= 1'b0;
      r_ie       <= 1'b0;
      r_s_u_p    <= 1'b0;
      r_ie_p     <= 1'b0;
      r_epc      <= '0;
      r_cause    <= '0;
      r_badvaddr <= '0;
    end else if (w_take_trap) begin
      r_epc   <= bus.pc_mem;
      r_cause <= w_trap_cause;
      if (w_save_bad) r_badvaddr <= bus.data_address;
      r_s_u_p <= r_s_u;
      r_ie_p  <= r_ie;
      r_ret   <= 1'b0;
      r_cnt   <= CNT_INIT;
    end else if (w_ret) begin
      r_ret <= 1'b1;
      r_cnt <= CNT_INIT;
    end else if (r_state == FLUSH) begin
      if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
    end else if (r_state == LOAD) begin
      if (r_ret) begin
        r_s_u <= r_s_u_p;
        r_ie  <= r_ie_p;
      end else begin
        r_s_u <= 1'b0;
        r_ie  <= 1'b0;
      end
    end
  end

  assign bus.kill_mem  = w_kill_mem;
  assign bus.flush     = w_flush;
  assign bus.stall     = w_stall;
  assign bus.pc_load   = w_pc_load;
  assign bus.pc_target = w_pc_target;
  assign bus.epc       = r_epc;
  assign bus.cause     = r_cause;
  assign bus.badvaddr  = r_badvaddr;
  assign bus.s_u       = r_s_u;
  assign bus.ie        = r_ie;

endmodule
